seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter N_W, default 32: dividend and quotient width.
REQ-002 Parameter D_W, default 16: divisor and remainder width; D_W SHALL be less than or equal to N_W.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a division; sampled on rising clk.
REQ-006 dividend  input  N_W  unsigned numerator; captured only when start is accepted.
REQ-007 divisor  input  D_W  unsigned denominator; captured only when start is accepted.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 div_by_zero  output  1  high with done when the captured divisor was 0; held with the results.
REQ-011 quotient  output  N_W  unsigned quotient.
REQ-012 remainder  output  D_W  unsigned remainder.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored with no effect on operands or results.
REQ-015 On acceptance at edge E with divisor != 0: capture operands, clear the working partial remainder, set iteration count to N_W, go to RUN; busy=1 from E.
REQ-016 RUN SHALL use restoring division, one quotient bit per cycle, MSB first: shift in the next dividend bit, trial-subtract the divisor at D_W+1 bits, keep the difference and set the quotient bit to 1 if non-negative, otherwise restore and set the bit to 0.
REQ-017 After N_W RUN cycles, at edge E+N_W, the FSM SHALL enter DONE: done=1, busy=0, quotient and remainder valid, div_by_zero=0.
REQ-018 DONE SHALL last one cycle, then go to IDLE; an accepted start in DONE SHALL begin a new operation per REQ-015 or REQ-019.
REQ-019 On acceptance with divisor == 0: go directly to DONE at edge E+1 with div_by_zero=1, quotient all ones, remainder = dividend[D_W-1:0], and busy=0 throughout.
REQ-020 quotient, remainder and div_by_zero SHALL hold their last values until the next operation completes; they SHALL NOT change during RUN.
REQ-021 The block SHALL meet quotient*divisor + remainder == dividend and remainder < divisor for all nonzero divisors; intermediate values SHALL NOT overflow.
REQ-022 busy and done SHALL never both be high.

Reset
REQ-023 When rst_n is low, the FSM SHALL go to IDLE and busy, done, div_by_zero, quotient, remainder and all internal registers SHALL be 0, immediately and independent of clk.
REQ-024 Reset mid-RUN SHALL abandon the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.
REQ-025 Outputs SHALL stay at reset values until the first operation completes.

Verification (N_W=32, D_W=16)
REQ-026 dividend=100000, divisor=7, start 1 cycle -> done exactly 32 cycles after acceptance, quotient=14285, remainder=5, div_by_zero=0.
REQ-027 dividend=0xFFFFFFFF, divisor=0xFFFF -> quotient=0x00010001, remainder=0; dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-028 dividend=5, divisor=0 -> done one cycle after acceptance, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5, busy never high.
REQ-029 start held high with changing operands during RUN -> results match the first captured operands only; an immediate restart from DONE produces correct back-to-back results.
REQ-030 rst_n low at RUN cycle 10 -> all outputs 0 at once, no done; next operation 1000/3 -> quotient=333, remainder=1.
REQ-031 200 random operand pairs, nonzero divisor -> each satisfies REQ-021, checked against the team's 16x16 array multiplier for divisor*quotient[15:0] when quotient fits in 16 bits.

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider: operands and start go in,
// status flags and the held quotient/remainder come back.
interface seq_divider_if #(
    parameter int N_W = 32,
    parameter int D_W = 16
);
    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock, MSB first.
// Results are held in output registers until the next operation finishes.
module seq_divider #(
    parameter int N_W = 32,
    parameter int D_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(N_W + 1);
    localparam logic [CW-1:0] N_ITER = CW'(N_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [N_W-1:0] shift_q;
    logic [D_W-1:0] divisor_q;
    logic [D_W-1:0] part_rem;
    logic [CW-1:0]  count;
    logic           zero_div;

    logic           busy_q;
    logic           done_q;
    logic           dz_q;
    logic [N_W-1:0] quo_q;
    logic [D_W-1:0] rem_q;

    logic [D_W:0]   trial;
    logic [D_W+1:0] diff;
    logic           trial_ok;
    logic [D_W-1:0] next_rem;
    logic [N_W-1:0] next_shift;

    // shift_q starts as the dividend; its MSB feeds the partial remainder each
    // step while the new quotient bit enters at the LSB, so it ends as the quotient.
    // The shifted partial remainder is below 2*divisor, so D_W+1 bits never overflow.
    always_comb begin
        trial      = {part_rem, shift_q[N_W-1]};
        diff       = {1'b0, trial} - {2'b00, divisor_q};
        trial_ok   = ~diff[D_W+1];
        next_rem   = trial_ok ? diff[D_W-1:0] : trial[D_W-1:0];
        next_shift = {shift_q[N_W-2:0], trial_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            divisor_q <= '0;
            part_rem  <= '0;
            count     <= '0;
            zero_div  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shift_q   <= bus.dividend;
                        divisor_q <= bus.divisor;
                        part_rem  <= '0;
                        state     <= RUN;
                        // A zero divisor spends one silent RUN cycle, busy stays low.
                        if (bus.divisor == '0) begin
                            zero_div <= 1'b1;
                            busy_q   <= 1'b0;
                            count    <= '0;
                        end else begin
                            zero_div <= 1'b0;
                            busy_q   <= 1'b1;
                            count    <= N_ITER;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (zero_div) begin
                        zero_div <= 1'b0;
                        state    <= DONE;
                        done_q   <= 1'b1;
                        dz_q     <= 1'b1;
                        quo_q    <= '1;
                        rem_q    <= shift_q[D_W-1:0];
                    end else begin
                        shift_q  <= next_shift;
                        part_rem <= next_rem;
                        count    <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            dz_q   <= 1'b0;
                            quo_q  <= next_shift;
                            rem_q  <= next_rem;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, held-start and restart,
// mid-run reset, then random operands compared against plain integer division.
module tb_seq_divider;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int total = 0;
    int bad   = 0;

    seq_divider_if #(.N_W(32), .D_W(16)) bus ();

    seq_divider #(.N_W(32), .D_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_output({tag, "_done"}, 64'(bus.done), 64'd0);
        check_output({tag, "_dz"},   64'(bus.div_by_zero), 64'd0);
        check_output({tag, "_q"},    64'(bus.quotient), 64'd0);
        check_output({tag, "_r"},    64'(bus.remainder), 64'd0);
    endtask

    // One complete operation: start for one cycle, wait for done, compare with
    // ordinary integer division, then confirm the results hold a cycle later.
    task automatic apply_stimulus(input logic [31:0] n, input logic [15:0] d, input string tag);
        int lat;
        bit busy_hi;
        bit both_hi;
        logic [31:0] exp_q;
        logic [15:0] exp_r;
        exp_q = (d == 16'd0) ? 32'hFFFF_FFFF : n / {16'd0, d};
        exp_r = (d == 16'd0) ? n[15:0] : 16'(n % {16'd0, d});
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_output({tag, "_busy0"}, 64'(bus.busy), 64'(d != 16'd0));
        lat     = 0;
        busy_hi = bus.busy;
        both_hi = 1'b0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            busy_hi = busy_hi | bus.busy;
            both_hi = both_hi | (bus.busy & bus.done);
        end
        check_output({tag, "_lat"},  64'(lat), (d == 16'd0) ? 64'd1 : 64'd32);
        check_output({tag, "_q"},    64'(bus.quotient), 64'(exp_q));
        check_output({tag, "_r"},    64'(bus.remainder), 64'(exp_r));
        check_output({tag, "_dz"},   64'(bus.div_by_zero), 64'(d == 16'd0));
        check_output({tag, "_bsyseen"}, 64'(busy_hi), 64'(d != 16'd0));
        check_output({tag, "_both"}, 64'(both_hi), 64'd0);
        @(posedge clk); #1;
        check_output({tag, "_pulse"}, 64'(bus.done), 64'd0);
        check_output({tag, "_hold"},  64'(bus.quotient), 64'(exp_q));
    endtask

    initial begin
        int lat;
        bit seen_done;
        logic [31:0] n;
        logic [15:0] d;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("post_reset");

        apply_stimulus(32'd100000, 16'd7, "vec100000_7");
        check_output("vec100000_7_lit_q", 64'(bus.quotient), 64'd14285);
        check_output("vec100000_7_lit_r", 64'(bus.remainder), 64'd5);
        apply_stimulus(32'hFFFF_FFFF, 16'hFFFF, "vecmax");
        check_output("vecmax_lit_q", 64'(bus.quotient), 64'h0001_0001);
        apply_stimulus(32'd3, 16'd10, "vec3_10");
        apply_stimulus(32'd5, 16'd0, "divzero");
        check_output("divzero_lit_r", 64'(bus.remainder), 64'd5);

        // Start held high while operands wander during RUN.
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = 32'd123456789;
        bus.divisor  = 16'd1000;
        @(posedge clk); #1;
        lat = 0;
        while (!bus.done && lat < 40) begin
            bus.dividend = $urandom;
            bus.divisor  = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check_output("held_lat", 64'(lat), 64'd32);
        check_output("held_q",   64'(bus.quotient), 64'd123456);
        check_output("held_r",   64'(bus.remainder), 64'd789);

        // Restart straight from DONE; previous results must stay put during RUN.
        bus.dividend = 32'd999999;
        bus.divisor  = 16'd77;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_output("b2b_busy", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 16) check_output("b2b_run_hold", 64'(bus.quotient), 64'd123456);
        end
        check_output("b2b_lat", 64'(lat), 64'd32);
        check_output("b2b_q",   64'(bus.quotient), 64'(32'd999999 / 32'd77));
        check_output("b2b_r",   64'(bus.remainder), 64'(32'd999999 % 32'd77));

        // Reset in the middle of RUN abandons the operation.
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = 32'd1000000;
        bus.divisor  = 16'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_zero_outputs("midrun_rst");
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen_done = seen_done | bus.done;
        end
        rst_n = 1'b1;
        repeat (36) begin
            @(posedge clk); #1;
            seen_done = seen_done | bus.done;
        end
        check_output("midrun_nodone", 64'(seen_done), 64'd0);
        apply_stimulus(32'd1000, 16'd3, "after_rst");
        check_output("after_rst_lit_q", 64'(bus.quotient), 64'd333);
        check_output("after_rst_lit_r", 64'(bus.remainder), 64'd1);

        for (int i = 0; i < 200; i++) begin
            n = (i % 4 == 0) ? 32'($urandom_range(0, 70000)) : $urandom;
            d = (i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
            apply_stimulus(n, d, $sformatf("rand%0d", i));
            check_output($sformatf("rand%0d_ident", i),
                         64'(bus.quotient) * 64'(d) + 64'(bus.remainder), 64'(n));
            check_output($sformatf("rand%0d_rlt", i), 64'(bus.remainder < d), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
